mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single synchronous instruction/data memory between the CPU core (port 0) and the host/debug loader (port 1).
- Serialises accesses with one transaction outstanding at a time.
- Drives the memory write-enable, address and data lines.
- Returns read data to the winning requester after a fixed memory read latency.
- Sits between the cpu, the host interface and the memory macro in the top-level.

Parameters:
ADDR_W, 14, memory word-address/byte-address width passed through unchanged
DATA_W, 32, data width
READ_LATENCY, 2, cycles from o_mem_addr presented to i_mem_data valid; legal range 1..15

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_m0_req  input  1  port 0 (cpu) request; held until o_m0_gnt
i_m0_we  input  1  port 0 write (1) / read (0)
i_m0_addr  input  ADDR_W  port 0 address
i_m0_wdata  input  DATA_W  port 0 write data
o_m0_gnt  output  1  one-cycle pulse: port 0 request accepted
o_m0_rvalid  output  1  one-cycle pulse: o_m0_rdata valid
o_m0_rdata  output  DATA_W  port 0 read data
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as port 0, for port 1 (host)
o_mem_write_en  output  1  memory write strobe
o_mem_addr  output  ADDR_W  memory address
o_mem_data  output  DATA_W  memory write data
i_mem_data  input  DATA_W  memory read data
o_busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs registered. i_rst asserted clears immediately:
  - o_mem_write_en=0, o_mem_addr=0, o_mem_data=0.
  - o_mN_gnt=0, o_mN_rvalid=0, o_mN_rdata=0.
  - state=IDLE, wait counter=0, rr_last=1 (port 0 wins the first tie).
- States: IDLE, ISSUE, WAIT.
- IDLE: sample requests on cycle T.
  - None pending: stay in IDLE.
  - Exactly one pending: select it.
  - Both pending: select the port != rr_last.
  - On select, at the T edge: load o_mem_addr/o_mem_data from the winner, set o_mem_write_en=winner we, pulse winner gnt, record owner and we, set rr_last=winner, go to ISSUE.
- ISSUE (cycle T+1): o_mem_* valid, gnt high for this cycle only. Requests are not sampled here; the requester may drop or change req after seeing gnt.
  - Write: next state IDLE; o_mem_write_en returns to 0 at T+2 (exactly one cycle high).
  - Read: load counter=READ_LATENCY-1, go to WAIT. o_mem_write_en stays 0 and o_mem_addr is held.
- WAIT: decrement counter each cycle. When counter==0, capture i_mem_data into owner rdata, pulse owner rvalid in the next cycle, and go to IDLE.
  - Read data appears on o_mN_rvalid at cycle T+2+READ_LATENCY.
- Throughput:
  - Write: one every 2 cycles.
  - Read: one every READ_LATENCY+2 cycles.
  - IDLE may accept a new request in the same cycle rvalid is high.
- o_mN_rdata holds its last value until the next read completes on that port; the non-owner port's rdata is untouched.
- o_mem_addr/o_mem_data hold their last values in IDLE; only write_en gates memory effect.
- Requests whose fields change while req is high and ungranted are sampled as presented at the accepting edge (requester contract: hold stable).
- Reset mid-transaction: in-flight read dropped, no rvalid, no write strobe after reset.

Optional Feature:
MEM_ARB_HOST_PRIORITY_EN
- Defined: port 1 (host) wins every tie regardless of rr_last, so the cpu may starve while the host streams. rr_last is still updated but unused.
- Undefined: round-robin as above; neither port waits more than one foreign transaction once requesting.

Test Plan:
- Single read: preload mem[0x010]=0xDEADBEEF, m0 read addr 0x010 at cycle 0 -> o_m0_gnt at cycle 1, o_mem_write_en=0, o_m0_rvalid with 0xDEADBEEF at cycle 4 (READ_LATENCY=2); m1 outputs unchanged.
- Single write: m1 write addr 0x020 data 0x12345678 -> o_mem_write_en high exactly cycle 1 with addr 0x020, data 0x12345678; no rvalid; o_busy low again at cycle 2.
- Tie round-robin: both ports hold write requests for 4 transactions -> grants alternate m0, m1, m0, m1 at cycles 1, 3, 5, 7. With MEM_ARB_HOST_PRIORITY_EN: m1, m1, ... until m1 drops req.
- Read then back-to-back: m0 read followed by m1 read queued -> m1 gnt not before m0 rvalid cycle; m1 data returned on o_m1_rdata only, o_m0_rdata retains previous value.
- Reset mid-read: assert i_rst asynchronously during WAIT -> all outputs 0 immediately, no rvalid after deassert, next request granted normally with m0 winning a tie.
- READ_LATENCY=1 and 15 sweeps: rvalid at cycle T+3 and T+17 respectively, data matches preloaded memory.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter for one synchronous memory; define MEM_ARB_HOST_PRIORITY_EN to give port 1 every tie
module mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);
  state_t     r_state, w_next;
  logic       r_owner, r_we, r_rr_last;
  logic [3:0] r_cnt;
  logic       w_any, w_tie_pick, w_win, w_win_we;
  assign o_busy = (r_state != IDLE);
  // pick the winner among the requests presented this cycle
  always_comb begin
    w_any      = i_m0_req | i_m1_req;
`ifdef MEM_ARB_HOST_PRIORITY_EN
    w_tie_pick = 1'b1;
`else
    w_tie_pick = ~r_rr_last;
`endif
    w_win      = (i_m0_req & i_m1_req) ? w_tie_pick : i_m1_req;
    w_win_we   = w_win ? i_m1_we : i_m0_we;
  end
  // next state: accept in IDLE, writes finish after ISSUE, reads wait out the latency
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_any ? ISSUE : IDLE) :
             (r_state == ISSUE) ? (r_we ? IDLE : WAIT) :
             (r_cnt == 4'd0)    ? IDLE : WAIT;
  end
  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // datapath: latch the winner onto the memory bus, pulse handshakes, return read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_write_en <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_data     <= '0;
      o_m0_gnt       <= 1'b0;
      o_m1_gnt       <= 1'b0;
      o_m0_rvalid    <= 1'b0;
      o_m1_rvalid    <= 1'b0;
      o_m0_rdata     <= '0;
      o_m1_rdata     <= '0;
      r_owner        <= 1'b0;
      r_we           <= 1'b0;
      r_rr_last      <= 1'b1;
      r_cnt          <= 4'd0;
    end else begin
      o_mem_write_en <= 1'b0;
      o_m0_gnt       <= 1'b0;
      o_m1_gnt       <= 1'b0;
      o_m0_rvalid    <= 1'b0;
      o_m1_rvalid    <= 1'b0;
      if (r_state == IDLE && w_any) begin
        o_mem_addr     <= w_win ? i_m1_addr : i_m0_addr;
        o_mem_data     <= w_win ? i_m1_wdata : i_m0_wdata;
        o_mem_write_en <= w_win_we;
        o_m0_gnt       <= ~w_win;
        o_m1_gnt       <= w_win;
        r_we           <= w_win_we;
        r_owner        <= w_win;
        r_rr_last      <= w_win;
      end
      if (r_state == ISSUE) r_cnt <= LAT_M1;
      if (r_state == WAIT) begin
        r_cnt <= (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
        if (r_cnt == 4'd0) begin
          o_m0_rvalid <= ~r_owner;
          o_m1_rvalid <= r_owner;
          if (r_owner) o_m1_rdata <= i_mem_data;
          else         o_m0_rdata <= i_mem_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int RL = 2;
`ifdef MEM_ARB_HOST_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, sweep = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [13:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic gnt0, gnt1, rv0, rv1, mwe, busy;
  logic [31:0] rd0, rd1, mdata, mrd;
  logic [13:0] maddr;
  logic l1_gnt0, l1_gnt1, l1_rv0, l1_rv1, l1_we, l1_busy;
  logic [31:0] l1_rd0, l1_rd1, l1_data, l1_mrd;
  logic [13:0] l1_addr;
  logic l15_gnt0, l15_gnt1, l15_rv0, l15_rv1, l15_we, l15_busy;
  logic [31:0] l15_rd0, l15_rd1, l15_data, l15_mrd;
  logic [13:0] l15_addr;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic pre_we = 0;
  logic [7:0] pre_addr = 0;
  logic [31:0] pre_data = 0;
  logic [31:0] p2 [2];
  logic [31:0] p1;
  logic [31:0] p15 [15];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(RL)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rd0),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rd1),
    .o_mem_write_en(mwe), .o_mem_addr(maddr), .o_mem_data(mdata), .i_mem_data(mrd), .o_busy(busy));

  mem_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req & sweep), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(l1_gnt0), .o_m0_rvalid(l1_rv0), .o_m0_rdata(l1_rd0),
    .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(14'd0), .i_m1_wdata(32'd0),
    .o_m1_gnt(l1_gnt1), .o_m1_rvalid(l1_rv1), .o_m1_rdata(l1_rd1),
    .o_mem_write_en(l1_we), .o_mem_addr(l1_addr), .o_mem_data(l1_data), .i_mem_data(l1_mrd), .o_busy(l1_busy));

  mem_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(15)) u_l15 (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req & sweep), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(l15_gnt0), .o_m0_rvalid(l15_rv0), .o_m0_rdata(l15_rd0),
    .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(14'd0), .i_m1_wdata(32'd0),
    .o_m1_gnt(l15_gnt1), .o_m1_rvalid(l15_rv1), .o_m1_rdata(l15_rd1),
    .o_mem_write_en(l15_we), .o_mem_addr(l15_addr), .o_mem_data(l15_data), .i_mem_data(l15_mrd), .o_busy(l15_busy));

  // memory macro: one shared array, a read pipeline per instance of its own depth
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mwe) mem[maddr[7:0]] <= mdata;
    p2[0] <= mem[maddr[7:0]];
    p2[1] <= p2[0];
    p1 <= mem[l1_addr[7:0]];
    p15[0] <= mem[l15_addr[7:0]];
    for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
  end
  assign mrd = p2[1];
  assign l1_mrd = p1;
  assign l15_mrd = p15[14];

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1; ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; m0_req = 0; m1_req = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_tests++; if ({gnt0, gnt1, rv0, rv1, mwe, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {gnt0, gnt1, rv0, rv1, mwe, busy}); end
    n_tests++; if (maddr !== 14'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", maddr); end
    n_tests++; if (mdata !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", mdata); end
    n_tests++; if ({rd0, rd1} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", rd0, rd1); end
    @(negedge clk);
    for (int a = 0; a < 256; a++) preload(8'(a), 32'hC0DE_0000 | 32'(a));
    preload(8'h10, 32'hDEAD_BEEF);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, mwe, gnt0, gnt1} !== 4'b0) begin n_fail++; $display("FAIL reset_idle got %b exp 0000", {busy, mwe, gnt0, gnt1}); end
  endtask

  task automatic test_single_read;
    m0_req = 1; m0_we = 0; m0_addr = 14'h010;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_tests++; if (gnt0 !== (k == 1)) begin n_fail++; $display("FAIL rd_gnt0 cyc%0d got %b exp %b", k, gnt0, k == 1); end
      n_tests++; if (rv0 !== (k == 4)) begin n_fail++; $display("FAIL rd_rvalid0 cyc%0d got %b exp %b", k, rv0, k == 4); end
      n_tests++; if ({gnt1, rv1, mwe} !== 3'b0) begin n_fail++; $display("FAIL rd_quiet cyc%0d got %b exp 000", k, {gnt1, rv1, mwe}); end
      n_tests++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL rd_rdata1 cyc%0d got %h exp 0", k, rd1); end
      if (k == 1) begin
        n_tests++; if (maddr !== 14'h010) begin n_fail++; $display("FAIL rd_addr got %h exp 010", maddr); end
        m0_req = 0;
      end
      if (k == 4) begin
        n_tests++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef", rd0); end
      end
    end
  endtask

  task automatic test_single_write;
    m1_req = 1; m1_we = 1; m1_addr = 14'h020; m1_wdata = 32'h1234_5678;
    ref_mem[8'h20] = 32'h1234_5678;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++; if (mwe !== (k == 1)) begin n_fail++; $display("FAIL wr_we cyc%0d got %b exp %b", k, mwe, k == 1); end
      n_tests++; if (busy !== (k == 1)) begin n_fail++; $display("FAIL wr_busy cyc%0d got %b exp %b", k, busy, k == 1); end
      n_tests++; if ({rv0, rv1} !== 2'b0) begin n_fail++; $display("FAIL wr_rvalid cyc%0d got %b exp 00", k, {rv0, rv1}); end
      n_tests++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rdata0 cyc%0d got %h exp deadbeef", k, rd0); end
      if (k == 1) begin
        n_tests++; if ({gnt1, maddr, mdata} !== {1'b1, 14'h020, 32'h1234_5678}) begin n_fail++; $display("FAIL wr_bus got %b %h %h exp 1 020 12345678", gnt1, maddr, mdata); end
        m1_req = 0;
      end
    end
  endtask

  task automatic test_round_robin;
    int td [11] = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 0, 0};
    int tp [11] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 1, 0};
    int q0, q1, e;
    do_reset;
    q0 = PRIO ? 1 : 2; q1 = PRIO ? 4 : 2;
    m0_req = 1; m0_we = 1; m0_addr = 14'h040; m0_wdata = $urandom;
    m1_req = 1; m1_we = 1; m1_addr = 14'h060; m1_wdata = $urandom;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = PRIO ? tp[k] : td[k];
      n_tests++; if ({gnt0, gnt1} !== {e == 1, e == 2}) begin n_fail++; $display("FAIL rr_gnt cyc%0d got %b%b exp %b%b", k, gnt0, gnt1, e == 1, e == 2); end
      if (e == 1) begin
        n_tests++; if ({mwe, maddr, mdata} !== {1'b1, m0_addr, m0_wdata}) begin n_fail++; $display("FAIL rr_bus0 cyc%0d got %h %h exp %h %h", k, maddr, mdata, m0_addr, m0_wdata); end
        ref_mem[m0_addr[7:0]] = m0_wdata;
        q0--; m0_req = (q0 > 0); m0_addr = m0_addr + 14'd1; m0_wdata = $urandom;
      end
      if (e == 2) begin
        n_tests++; if ({mwe, maddr, mdata} !== {1'b1, m1_addr, m1_wdata}) begin n_fail++; $display("FAIL rr_bus1 cyc%0d got %h %h exp %h %h", k, maddr, mdata, m1_addr, m1_wdata); end
        ref_mem[m1_addr[7:0]] = m1_wdata;
        q1--; m1_req = (q1 > 0); m1_addr = m1_addr + 14'd1; m1_wdata = $urandom;
      end
    end
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_back_to_back;
    m0_req = 1; m0_we = 0; m0_addr = 14'h020;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_tests++; if ({gnt0, gnt1, rv0, rv1} !== {k == 1, k == 5, k == 4, k == 8}) begin n_fail++; $display("FAIL b2b_hs cyc%0d got %b%b%b%b exp %b%b%b%b", k, gnt0, gnt1, rv0, rv1, k == 1, k == 5, k == 4, k == 8); end
      n_tests++; if (rd0 !== ((k < 4) ? 32'd0 : 32'h1234_5678)) begin n_fail++; $display("FAIL b2b_rdata0 cyc%0d got %h", k, rd0); end
      n_tests++; if (rd1 !== ((k < 8) ? 32'd0 : 32'hDEAD_BEEF)) begin n_fail++; $display("FAIL b2b_rdata1 cyc%0d got %h", k, rd1); end
      if (k == 1) begin m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 14'h010; end
      if (k == 5) m1_req = 0;
    end
  endtask

  task automatic test_reset_mid_read;
    m0_req = 1; m0_we = 0; m0_addr = 14'h010;
    @(negedge clk);
    m0_req = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({busy, mwe, gnt0, rv0} !== 4'b0) begin n_fail++; $display("FAIL mid_flags got %b exp 0000", {busy, mwe, gnt0, rv0}); end
    n_tests++; if ({maddr, rd0} !== 46'd0) begin n_fail++; $display("FAIL mid_clear got %h %h exp 0 0", maddr, rd0); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++; if ({rv0, rv1, mwe, busy} !== 4'b0) begin n_fail++; $display("FAIL mid_quiet cyc%0d got %b exp 0000", k, {rv0, rv1, mwe, busy}); end
    end
    m0_req = 1; m0_we = 1; m0_addr = 14'h050; m0_wdata = $urandom;
    m1_req = 1; m1_we = 1; m1_addr = 14'h051; m1_wdata = $urandom;
    @(negedge clk);
    n_tests++; if ({gnt0, gnt1} !== {!PRIO, PRIO}) begin n_fail++; $display("FAIL mid_tie got %b%b exp %b%b", gnt0, gnt1, !PRIO, PRIO); end
    if (PRIO) ref_mem[8'h51] = m1_wdata; else ref_mem[8'h50] = m0_wdata;
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_latency_sweep;
    do_reset;
    sweep = 1; m0_req = 1; m0_we = 0; m0_addr = 14'h010;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      n_tests++; if ({rv0, l1_rv0, l15_rv0} !== {k == 4, k == 3, k == 17}) begin n_fail++; $display("FAIL lat_rvalid cyc%0d got %b%b%b exp %b%b%b", k, rv0, l1_rv0, l15_rv0, k == 4, k == 3, k == 17); end
      if (k == 1) begin
        n_tests++; if ({gnt0, l1_gnt0, l15_gnt0} !== 3'b111) begin n_fail++; $display("FAIL lat_gnt got %b%b%b exp 111", gnt0, l1_gnt0, l15_gnt0); end
        m0_req = 0;
      end
      if (k == 3) begin n_tests++; if (l1_rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat1_data got %h exp deadbeef", l1_rd0); end end
      if (k == 4) begin n_tests++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat2_data got %h exp deadbeef", rd0); end end
      if (k == 17) begin n_tests++; if (l15_rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat15_data got %h exp deadbeef", l15_rd0); end end
    end
    sweep = 0;
  endtask

  task automatic test_random;
    int idle_from, rv_due;
    logic last, rv_port, rv_pend, win, eg0, eg1, ewe, er0, er1;
    logic [31:0] rv_dat, erd0, erd1, ed;
    logic [13:0] ea;
    do_reset;
    idle_from = 0; last = 1'b1; rv_pend = 1'b0; rv_due = 0; rv_port = 1'b0; rv_dat = '0;
    erd0 = '0; erd1 = '0; ea = '0; ed = '0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      eg0 = 0; eg1 = 0; ewe = 0;
      if (c - 1 >= idle_from && (m0_req || m1_req)) begin
        win = (m0_req && m1_req) ? (PRIO ? 1'b1 : !last) : m1_req;
        last = win; eg0 = !win; eg1 = win;
        ewe = win ? m1_we : m0_we;
        ea = win ? m1_addr : m0_addr;
        ed = win ? m1_wdata : m0_wdata;
        if (ewe) begin
          ref_mem[ea[7:0]] = ed; idle_from = c + 1;
        end else begin
          rv_pend = 1; rv_due = c + RL + 1; rv_port = win; rv_dat = ref_mem[ea[7:0]]; idle_from = c + RL + 1;
        end
      end
      er0 = rv_pend && rv_due == c && !rv_port;
      er1 = rv_pend && rv_due == c && rv_port;
      if (er0) erd0 = rv_dat;
      if (er1) erd1 = rv_dat;
      if (rv_due == c) rv_pend = 0;
      n_tests++; if ({gnt0, gnt1, mwe, busy} !== {eg0, eg1, ewe, c < idle_from}) begin n_fail++; $display("FAIL rnd_ctl cyc%0d got %b%b%b%b exp %b%b%b%b", c, gnt0, gnt1, mwe, busy, eg0, eg1, ewe, c < idle_from); end
      n_tests++; if ({rv0, rv1} !== {er0, er1}) begin n_fail++; $display("FAIL rnd_rvalid cyc%0d got %b%b exp %b%b", c, rv0, rv1, er0, er1); end
      n_tests++; if ({rd0, rd1} !== {erd0, erd1}) begin n_fail++; $display("FAIL rnd_rdata cyc%0d got %h %h exp %h %h", c, rd0, rd1, erd0, erd1); end
      if (eg0 || eg1) begin
        n_tests++; if ({maddr, mdata} !== {ea, ed}) begin n_fail++; $display("FAIL rnd_bus cyc%0d got %h %h exp %h %h", c, maddr, mdata, ea, ed); end
      end
      if (gnt0) m0_req = 0;
      if (gnt1) m1_req = 0;
      if (!m0_req && c < 1480 && $urandom_range(2) == 0) begin
        m0_req = 1; m0_we = 1'($urandom_range(1)); m0_addr = 14'($urandom_range(31)); m0_wdata = $urandom;
      end
      if (!m1_req && c < 1480 && $urandom_range(2) == 0) begin
        m1_req = 1; m1_we = 1'($urandom_range(1)); m1_addr = 14'($urandom_range(31)); m1_wdata = $urandom;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_round_robin;
    test_back_to_back;
    test_reset_mid_read;
    test_latency_sweep;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
